// File: rtl/svm_multiclass_if.sv
// Interface for svm_multiclass.
// Groups the coefficient-load, sample-in and result-out signals.
//   master : the side that loads coefficients and streams samples
//            (drives start/coef_valid/weight/alpha/DE_in/data_in).
//   slave  : the classifier (drives ready/DE_out/label/score/drop).
// LBL_W and ACC_W follow the same formulas as inside the classifier.
interface svm_multiclass_if #(
  parameter int nDims     = 2,
  parameter int nClasses  = 3,
  parameter int data_BW   = 16,
  parameter int weight_BW = 16,
  parameter int alpha_BW  = 16
);
  localparam int LBL_W = (nClasses > 1) ? $clog2(nClasses) : 1;
  localparam int ACC_W = data_BW + weight_BW + $clog2(nDims + 1) + 1;

  logic                     start;
  logic                     coef_valid;
  logic [weight_BW-1:0]     weight;
  logic [alpha_BW-1:0]      alpha;
  logic                     ready;
  logic                     DE_in;
  logic [nDims*data_BW-1:0] data_in;
  logic                     DE_out;
  logic [LBL_W-1:0]         label;
  logic [ACC_W-1:0]         score;
  logic                     drop;

  modport master (
    output start, coef_valid, weight, alpha, DE_in, data_in,
    input  ready, DE_out, label, score, drop
  );

  modport slave (
    input  start, coef_valid, weight, alpha, DE_in, data_in,
    output ready, DE_out, label, score, drop
  );
endinterface

// File: rtl/svm_multiclass.sv
// Linear one-vs-rest SVM classifier over nDims features and nClasses classes.
// After a start pulse the weights and bias of every class are loaded serially
// (class by class: nDims weights, then one bias). Once loaded, ready is high
// and one sample per cycle is classified with a fixed 3-cycle latency.
// nClasses=1 gives a binary sign classifier (label = score >= 0).
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : svm_multiclass_if.slave
//           start/coef_valid/weight/alpha : coefficient load
//           ready                         : coefficients loaded
//           DE_in/data_in                 : sample stream (dim 0 in LSBs)
//           DE_out/label/score            : classification result
//           drop                          : sticky, sample seen while not ready
module svm_multiclass #(
  parameter int nDims       = 2,
  parameter int nClasses    = 3,
  parameter int data_BW     = 16,
  parameter int data_FRAC   = 13,
  parameter int weight_BW   = 16,
  parameter int weight_FRAC = 15,
  parameter int alpha_BW    = 16,
  parameter int alpha_FRAC  = 11
) (
  input  logic              clk,
  input  logic              reset,
  svm_multiclass_if.slave   bus
);
  localparam int LBL_W  = (nClasses > 1) ? $clog2(nClasses) : 1;
  localparam int ACC_W  = data_BW + weight_BW + $clog2(nDims + 1) + 1;
  localparam int PROD_W = data_BW + weight_BW;
  localparam int SHIFT  = data_FRAC + weight_FRAC - alpha_FRAC;
  localparam int DIM_CW = $clog2(nDims + 1);
  localparam int CLS_CW = (nClasses > 1) ? $clog2(nClasses) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  // Full-precision product, sign-extended into the score width.
  function automatic logic signed [ACC_W-1:0] ext_prod(input logic signed [PROD_W-1:0] p);
    return ACC_W'(p);
  endfunction

  // Bias aligned to the product binary point.
  function automatic logic signed [ACC_W-1:0] ext_bias(input logic signed [alpha_BW-1:0] b);
    return ACC_W'(b) <<< SHIFT;
  endfunction

  state_t              state_q, state_d;
  logic [DIM_CW-1:0]   dim_cnt_q, dim_cnt_d;
  logic [CLS_CW-1:0]   cls_cnt_q, cls_cnt_d;
  logic                load_en;
  logic                accept;
  logic                drop_q, drop_d;
  logic                vld_p1_q, vld_p1_d;
  logic                vld_p2_q, vld_p2_d;
  logic                vld_p3_q, vld_p3_d;
  logic [LBL_W-1:0]    label_q, label_d;
  logic signed [ACC_W-1:0] score_q, score_d;

  logic signed [weight_BW-1:0] w_q [nClasses][nDims];
  logic signed [weight_BW-1:0] w_d [nClasses][nDims];
  logic signed [alpha_BW-1:0]  b_q [nClasses];
  logic signed [alpha_BW-1:0]  b_d [nClasses];

  logic signed [data_BW-1:0]   feat [nDims];
  logic signed [PROD_W-1:0]    prod_p1_q [nClasses][nDims];
  logic signed [PROD_W-1:0]    prod_p1_d [nClasses][nDims];
  logic signed [ACC_W-1:0]     sum_p2_q [nClasses];
  logic signed [ACC_W-1:0]     sum_p2_d [nClasses];
  logic signed [ACC_W-1:0]     best;
  logic [LBL_W-1:0]            best_idx;

  // Load sequencer. A word is consumed only on coef_valid; the counter pair
  // (cls, dim) walks weights 0..nDims-1 and then the bias slot dim==nDims.
  always_comb begin
    state_d   = state_q;
    dim_cnt_d = dim_cnt_q;
    cls_cnt_d = cls_cnt_q;
    load_en   = 1'b0;
    if (bus.start) begin
      state_d   = LOAD;
      dim_cnt_d = '0;
      cls_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE, RUN: ;
        LOAD: begin
          if (bus.coef_valid) begin
            load_en = 1'b1;
            if (dim_cnt_q == DIM_CW'(nDims)) begin
              dim_cnt_d = '0;
              if (cls_cnt_q == CLS_CW'(nClasses - 1)) begin
                cls_cnt_d = '0;
                state_d   = RUN;
              end else begin
                cls_cnt_d = cls_cnt_q + CLS_CW'(1);
              end
            end else begin
              dim_cnt_d = dim_cnt_q + DIM_CW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    w_d = w_q;
    b_d = b_q;
    for (int c = 0; c < nClasses; c++) begin
      for (int d = 0; d < nDims; d++) begin
        if (load_en && cls_cnt_q == CLS_CW'(c) && dim_cnt_q == DIM_CW'(d))
          w_d[c][d] = $signed(bus.weight);
      end
      if (load_en && cls_cnt_q == CLS_CW'(c) && dim_cnt_q == DIM_CW'(nDims))
        b_d[c] = $signed(bus.alpha);
    end
  end

  // A start pulse flushes every in-flight result.
  always_comb begin
    accept   = bus.DE_in && (state_q == RUN);
    drop_d   = drop_q | (bus.DE_in && (state_q != RUN));
    vld_p1_d = bus.start ? 1'b0 : accept;
    vld_p2_d = bus.start ? 1'b0 : vld_p1_q;
    vld_p3_d = bus.start ? 1'b0 : vld_p2_q;
  end

  // ---- S1: products of every feature with every class weight ----
  always_comb begin
    for (int d = 0; d < nDims; d++)
      feat[d] = $signed(bus.data_in[d*data_BW +: data_BW]);
    for (int c = 0; c < nClasses; c++)
      for (int d = 0; d < nDims; d++)
        prod_p1_d[c][d] = PROD_W'(feat[d]) * PROD_W'(w_q[c][d]);
  end

  // ---- S2: per-class dot product plus aligned bias ----
  always_comb begin
    for (int c = 0; c < nClasses; c++) begin
      sum_p2_d[c] = ext_bias(b_q[c]);
      for (int d = 0; d < nDims; d++)
        sum_p2_d[c] = sum_p2_d[c] + ext_prod(prod_p1_q[c][d]);
    end
  end

  // ---- S3: argmax (strict > keeps the lowest index on ties) ----
  always_comb begin
    best     = sum_p2_q[0];
    best_idx = '0;
    for (int c = 1; c < nClasses; c++) begin
      if (sum_p2_q[c] > best) begin
        best     = sum_p2_q[c];
        best_idx = LBL_W'(c);
      end
    end
    if (nClasses == 1)
      best_idx = LBL_W'(~sum_p2_q[0][ACC_W-1]);
    label_d = label_q;
    score_d = score_q;
    if (vld_p2_q && !bus.start) begin
      label_d = best_idx;
      score_d = best;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      dim_cnt_q <= '0;
      cls_cnt_q <= '0;
      drop_q    <= 1'b0;
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      vld_p3_q  <= 1'b0;
      label_q   <= '0;
      score_q   <= '0;
    end else begin
      state_q   <= state_d;
      dim_cnt_q <= dim_cnt_d;
      cls_cnt_q <= cls_cnt_d;
      drop_q    <= drop_d;
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      vld_p3_q  <= vld_p3_d;
      label_q   <= label_d;
      score_q   <= score_d;
    end
  end

  always_ff @(posedge clk) begin
    w_q       <= w_d;
    b_q       <= b_d;
    prod_p1_q <= prod_p1_d;
    sum_p2_q  <= sum_p2_d;
  end

  assign bus.ready  = (state_q == RUN);
  assign bus.DE_out = vld_p3_q;
  assign bus.label  = label_q;
  assign bus.score  = score_q;
  assign bus.drop   = drop_q;
endmodule

// File: tb/tb_svm_multiclass.sv
// Bench for svm_multiclass: two instances (3-class/2-dim and binary 3-dim).
// Stimulus pushes expected results into per-instance queues; a monitor per
// instance pops and compares whenever DE_out is high.
module tb_svm_multiclass;
  localparam int AD = 2, AC = 3;
  localparam int BD = 3, BC = 1;
  // bias is scaled to the product binary point: 13+15 frac bits vs 11
  localparam int SH = 13 + 15 - 11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  svm_multiclass_if #(.nDims(AD), .nClasses(AC)) ifa ();
  svm_multiclass_if #(.nDims(BD), .nClasses(BC)) ifb ();

  svm_multiclass #(.nDims(AD), .nClasses(AC)) dut_a (.clk(clk), .reset(rst), .bus(ifa));
  svm_multiclass #(.nDims(BD), .nClasses(BC)) dut_b (.clk(clk), .reset(rst), .bus(ifb));

  typedef struct {
    int     label;
    longint score;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int n_cmp = 0;
  int n_err = 0;
  int wa[AC][AD];
  int ba[AC];
  int wb[BD];
  int bb;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic int rnd16();
    logic signed [15:0] v;
    v = 16'($urandom);
    return int'(v);
  endfunction

  // Reference: score_c = sum_d x_d*w_cd + bias_c*2^SH, label = first maximum.
  function automatic exp_t model_a(input int x0, input int x1);
    exp_t e;
    longint s;
    int x[AD];
    x[0] = x0;
    x[1] = x1;
    e.label = 0;
    e.score = 0;
    for (int c = 0; c < AC; c++) begin
      s = longint'(ba[c]) * (longint'(1) << SH);
      for (int d = 0; d < AD; d++) s += longint'(x[d]) * longint'(wa[c][d]);
      if (c == 0 || s > e.score) begin
        e.score = s;
        e.label = c;
      end
    end
    return e;
  endfunction

  function automatic exp_t model_b(input int x0, input int x1, input int x2);
    exp_t e;
    e.score = longint'(bb) * (longint'(1) << SH) + longint'(x0) * wb[0]
            + longint'(x1) * wb[1] + longint'(x2) * wb[2];
    e.label = (e.score >= 0) ? 1 : 0;
    return e;
  endfunction

  task automatic start_pulse(input bit on_a);
    if (on_a) ifa.start = 1'b1; else ifb.start = 1'b1;
    cyc();
    ifa.start = 1'b0;
    ifb.start = 1'b0;
  endtask

  // gapmode: 0 dense, 1 coef_valid every other cycle, 2 random idle cycles
  task automatic load_a(input int gapmode);
    int words[$];
    int n;
    for (int c = 0; c < AC; c++) begin
      for (int d = 0; d < AD; d++) words.push_back(wa[c][d]);
      words.push_back(ba[c]);
    end
    for (int i = 0; i < words.size(); i++) begin
      n = (gapmode == 1 && i > 0) ? 1 : (gapmode == 2) ? $urandom_range(0, 2) : 0;
      for (int g = 0; g < n; g++) begin
        ifa.coef_valid = 1'b0;
        ifa.weight = 16'($urandom);
        ifa.alpha  = 16'($urandom);
        cyc();
      end
      if (i == words.size() - 1) check("a_ready_before_last_word", longint'(ifa.ready), 0);
      ifa.coef_valid = 1'b1;
      if ((i % (AD + 1)) == AD) begin
        ifa.alpha  = 16'(words[i]);
        ifa.weight = 16'($urandom);
      end else begin
        ifa.weight = 16'(words[i]);
        ifa.alpha  = 16'($urandom);
      end
      cyc();
    end
    ifa.coef_valid = 1'b0;
    check("a_ready_after_load", longint'(ifa.ready), 1);
  endtask

  task automatic load_b();
    int words[$];
    for (int d = 0; d < BD; d++) words.push_back(wb[d]);
    words.push_back(bb);
    for (int i = 0; i < words.size(); i++) begin
      ifb.coef_valid = 1'b1;
      if (i == BD) begin
        ifb.alpha  = 16'(words[i]);
        ifb.weight = 16'($urandom);
      end else begin
        ifb.weight = 16'(words[i]);
        ifb.alpha  = 16'($urandom);
      end
      cyc();
    end
    ifb.coef_valid = 1'b0;
    check("b_ready_after_load", longint'(ifb.ready), 1);
  endtask

  task automatic send_a(input int x0, input int x1, input bit expect_out);
    ifa.DE_in   = 1'b1;
    ifa.data_in = {16'(x1), 16'(x0)};
    if (expect_out) qa.push_back(model_a(x0, x1));
    cyc();
    ifa.DE_in = 1'b0;
  endtask

  task automatic send_b(input int x0, input int x1, input int x2);
    ifb.DE_in   = 1'b1;
    ifb.data_in = {16'(x2), 16'(x1), 16'(x0)};
    qb.push_back(model_b(x0, x1, x2));
    cyc();
    ifb.DE_in = 1'b0;
  endtask

  task automatic set_a_coefs(input int w00, input int w01, input int w10, input int w11,
                             input int w20, input int w21, input int b0, input int b1, input int b2);
    wa[0][0] = w00; wa[0][1] = w01;
    wa[1][0] = w10; wa[1][1] = w11;
    wa[2][0] = w20; wa[2][1] = w21;
    ba[0] = b0; ba[1] = b1; ba[2] = b2;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (ifa.DE_out === 1'b1) begin
      if (qa.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL a_unexpected_out: got DE_out=1, required 0");
      end else begin
        e = qa.pop_front();
        check("a_label", longint'(ifa.label), longint'(e.label));
        check("a_score", longint'($signed(ifa.score)), e.score);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (ifb.DE_out === 1'b1) begin
      if (qb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL b_unexpected_out: got DE_out=1, required 0");
      end else begin
        e = qb.pop_front();
        check("b_label", longint'(ifb.label), longint'(e.label));
        check("b_score", longint'($signed(ifb.score)), e.score);
      end
    end
  end

  initial begin
    rst = 1'b1;
    ifa.start = 1'b0; ifa.coef_valid = 1'b0; ifa.weight = '0; ifa.alpha = '0;
    ifa.DE_in = 1'b0; ifa.data_in = '0;
    ifb.start = 1'b0; ifb.coef_valid = 1'b0; ifb.weight = '0; ifb.alpha = '0;
    ifb.DE_in = 1'b0; ifb.data_in = '0;
    repeat (3) cyc();
    rst = 1'b0;
    cyc();

    check("a_reset_ready",  longint'(ifa.ready), 0);
    check("a_reset_de_out", longint'(ifa.DE_out), 0);
    check("a_reset_label",  longint'(ifa.label), 0);
    check("a_reset_score",  longint'(ifa.score), 0);
    check("a_reset_drop",   longint'(ifa.drop), 0);
    check("b_reset_ready",  longint'(ifb.ready), 0);
    check("b_reset_score",  longint'(ifb.score), 0);

    // Sample before any load: dropped, drop becomes sticky.
    send_a(16'h0100, 16'h0200, 1'b0);
    repeat (4) cyc();
    check("a_drop_set", longint'(ifa.drop), 1);
    check("a_ready_idle", longint'(ifa.ready), 0);

    // Directed classification with an exact 3-cycle latency check.
    set_a_coefs(16'h4000, 0, 0, 16'h4000, 0, 0, 0, 0, 16'h00CD);
    start_pulse(1'b1);
    check("a_ready_after_start", longint'(ifa.ready), 0);
    load_a(0);
    send_a(16'h1000, 16'h0800, 1'b1);
    cyc();
    check("a_latency_early", longint'(ifa.DE_out), 0);
    cyc();
    check("a_latency_exact", longint'(ifa.DE_out), 1);
    cyc();
    check("a_de_out_single", longint'(ifa.DE_out), 0);
    check("a_label_hold", longint'(ifa.label), 0);

    // Back-to-back samples; the second wins on bias only.
    send_a(16'h0800, 16'h1000, 1'b1);
    send_a(0, 0, 1'b1);
    repeat (5) cyc();

    // coef_valid outside the load phase must not disturb coefficients.
    for (int i = 0; i < 4; i++) begin
      ifa.coef_valid = 1'b1;
      ifa.weight = 16'($urandom);
      ifa.alpha  = 16'($urandom);
      cyc();
    end
    ifa.coef_valid = 1'b0;
    send_a(16'h1000, 16'h0800, 1'b1);
    repeat (4) cyc();

    // Tie between classes 0 and 1.
    set_a_coefs(16'h4000, 16'h4000, 16'h4000, 16'h4000, 0, 0, 0, 0, 0);
    start_pulse(1'b1);
    load_a(0);
    send_a(16'h1000, 16'h1000, 1'b1);
    repeat (4) cyc();

    // Toggled coef_valid during load.
    set_a_coefs(16'h4000, 0, 0, 16'h4000, 0, 0, 0, 0, 16'h00CD);
    start_pulse(1'b1);
    load_a(1);
    send_a(16'h1000, 16'h0800, 1'b1);
    repeat (4) cyc();

    // Randomized coefficients, stalls and sample streams.
    for (int r = 0; r < 4; r++) begin
      set_a_coefs(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(),
                  rnd16(), rnd16(), rnd16());
      if (r == 3) begin
        wa[2][0] = wa[0][0]; wa[2][1] = wa[0][1]; ba[2] = ba[0];
      end
      start_pulse(1'b1);
      load_a(2);
      for (int s = 0; s < 25; s++) begin
        send_a(rnd16(), rnd16(), 1'b1);
        if ($urandom_range(0, 3) == 0) cyc();
      end
      repeat (4) cyc();
    end

    // start with two samples in flight: both results discarded.
    send_a(rnd16(), rnd16(), 1'b0);
    send_a(rnd16(), rnd16(), 1'b0);
    start_pulse(1'b1);
    check("a_ready_flush", longint'(ifa.ready), 0);
    repeat (5) cyc();
    check("a_ready_wait_load", longint'(ifa.ready), 0);
    load_a(2);
    send_a(rnd16(), rnd16(), 1'b1);
    repeat (4) cyc();
    check("a_drop_sticky", longint'(ifa.drop), 1);

    // Binary instance.
    wb[0] = 16'h4000; wb[1] = 16'h4000; wb[2] = 16'h4000; bb = -16'sh0800;
    start_pulse(1'b0);
    load_b();
    send_b(16'h1000, 0, 0);
    send_b(16'h1000, 16'h1000, 16'h1000);
    send_b(16'h2000, 16'h2000, 16'h2000);
    send_b(16'h2000, 16'h2000, 0);
    repeat (4) cyc();
    for (int r = 0; r < 2; r++) begin
      wb[0] = rnd16(); wb[1] = rnd16(); wb[2] = rnd16(); bb = rnd16();
      start_pulse(1'b0);
      load_b();
      for (int s = 0; s < 20; s++) send_b(rnd16(), rnd16(), rnd16());
      repeat (4) cyc();
    end
    check("b_drop_clear", longint'(ifb.drop), 0);

    for (int i = 0; i < 50 && (qa.size() != 0 || qb.size() != 0); i++) cyc();
    check("a_drain", longint'(qa.size()), 0);
    check("b_drain", longint'(qb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
